// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - SHA-256 message padder: byte stream in, 64-byte padded blocks out
// Passes message bytes through, then appends 0x80, zero fill and the 64-bit big-endian bit length.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] msg_data,
  input  logic       msg_valid,
  input  logic       msg_last,
  output logic       msg_ready,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       out_ready,
  output logic       block_last,
  output logic       msg_end
);

  typedef enum logic [1:0] {
    ST_MSG,
    ST_PAD,
    ST_ZERO,
    ST_LEN
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         byte_idx_q, byte_idx_d;
  logic [LEN_W-1:0]   bit_len_q, bit_len_d;
  logic [63:0]        len64;
  logic [7:0]         len_byte;
  logic               in_xfer;
  logic               out_xfer;

  // Length field is always 64 bits on the wire; byte_idx 56..63 selects bits 63:56 down to 7:0.
  assign len64    = 64'(bit_len_q);
  assign len_byte = 8'(len64 >> {3'd7 - byte_idx_q[2:0], 3'b000});

  // Outputs are forced low while reset_n is asserted, independent of the clock.
  always_comb begin
    msg_ready = 1'b0;
    valid_out = 1'b0;
    data_out  = 8'h00;
    if (reset_n) begin
      case (state_q)
        ST_MSG: begin
          data_out  = msg_data;
          valid_out = msg_valid;
          msg_ready = out_ready;
        end
        ST_PAD: begin
          data_out  = 8'h80;
          valid_out = 1'b1;
        end
        ST_ZERO: begin
          data_out  = 8'h00;
          valid_out = 1'b1;
        end
        default: begin
          data_out  = len_byte;
          valid_out = 1'b1;
        end
      endcase
    end
  end

  assign in_xfer    = msg_valid && msg_ready;
  assign out_xfer   = valid_out && out_ready;
  assign block_last = valid_out && (byte_idx_q == 6'd63);
  assign msg_end    = valid_out && (state_q == ST_LEN) && (byte_idx_q == 6'd63);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_len_d  = bit_len_q;
    if (out_xfer) begin
      byte_idx_d = byte_idx_q + 6'd1;
    end
    if (in_xfer) begin
      bit_len_d = bit_len_q + LEN_W'(8);
    end
    case (state_q)
      ST_MSG: begin
        if (in_xfer && msg_last) begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (out_xfer) begin
          state_d = (byte_idx_q == 6'd55) ? ST_LEN : ST_ZERO;
        end
      end
      ST_ZERO: begin
        if (out_xfer && byte_idx_q == 6'd55) begin
          state_d = ST_LEN;
        end
      end
      default: begin
        if (out_xfer && byte_idx_q == 6'd63) begin
          state_d   = ST_MSG;
          bit_len_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_MSG;
      byte_idx_q <= 6'd0;
      bit_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_len_q  <= bit_len_d;
    end
  end

endmodule

// File: doc/sha256_msg_padder.md
SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 64: width of the message bit-length counter; legal range 16..64.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port msg_data  input  8  raw message byte from upstream.
REQ-005 SHALL have port msg_valid  input  1  msg_data is valid.
REQ-006 SHALL have port msg_last  input  1  qualifies msg_data as the final byte of the message.
REQ-007 SHALL have port msg_ready  output  1  padder accepts msg_data this cycle.
REQ-008 SHALL have port data_out  output  8  padded byte stream to the hash core's data_in.
REQ-009 SHALL have port valid_out  output  1  data_out is valid; drives the hash core's valid_in.
REQ-010 SHALL have port out_ready  input  1  the hash core accepts data_out this cycle.
REQ-011 SHALL have port block_last  output  1  high with valid_out on byte 63 of every 64-byte block.
REQ-012 SHALL have port msg_end  output  1  high with valid_out on the final length byte of a message.

Function
REQ-013 An output transfer SHALL occur on a rising edge with valid_out=1 and out_ready=1; an input transfer SHALL occur with msg_valid=1 and msg_ready=1.
REQ-014 A 6-bit byte_idx SHALL increment on every output transfer and wrap from 63 to 0.
REQ-015 An LEN_W-bit bit_len SHALL add 8 on every input transfer, wrapping modulo 2^LEN_W.
REQ-016 The FSM SHALL have exactly four states: MSG, PAD, ZERO and LEN.
REQ-017 In MSG (zero latency, combinational): data_out=msg_data, valid_out=msg_valid, msg_ready=out_ready.
REQ-018 In MSG, an input transfer with msg_last=1 SHALL move the FSM to PAD.
REQ-019 In PAD, ZERO and LEN: msg_ready=0 and valid_out=1.
REQ-020 PAD SHALL output 0x80. On transfer it moves to LEN if byte_idx was 55, else to ZERO.
REQ-021 ZERO SHALL output 0x00. On transfer it moves to LEN when byte_idx was 55, else stays in ZERO, crossing a block wrap if required.
REQ-022 LEN SHALL output bit_len zero-extended to 64 bits, big-endian: byte_idx 56 carries bits 63:56 and byte_idx 63 carries bits 7:0.
REQ-023 On the LEN transfer at byte_idx 63: msg_end=1; FSM returns to MSG; bit_len clears to 0.
REQ-024 block_last SHALL equal valid_out AND (byte_idx==63) in every state.
REQ-025 While valid_out=1 and out_ready=0, data_out SHALL be held stable in PAD, ZERO and LEN; in MSG it relies on upstream holding msg_data.
REQ-026 msg_last with msg_valid=0 SHALL be ignored; zero-length messages are unsupported.
REQ-027 A new message MAY be accepted in the cycle following the msg_end transfer, with no dead cycle.
REQ-028 Every message SHALL produce an output byte count that is a multiple of 64.

Reset
REQ-029 While reset_n=0: FSM=MSG, byte_idx=0, bit_len=0, and valid_out, msg_ready, block_last and msg_end are all forced to 0; data_out=0x00.
REQ-030 Reset asserted mid-message SHALL discard all partial state; the first message after release starts at byte_idx 0 with bit_len 0.

Verification
REQ-031 "abc" (61 62 63, last on 63) -> 64 bytes out: 61 62 63 80, 52×00, then 00 00 00 00 00 00 00 18; block_last and msg_end both high on byte 63.
REQ-032 55-byte message -> 0x80 at index 55, no ZERO state, length bytes 00..01 B8 at indices 56-63; 64 bytes total.
REQ-033 56-byte message -> 128 bytes: 0x80 at 56, 00 at 57-119, length 00..01 C0 at 120-127; block_last at 63 and at 127, msg_end only at 127.
REQ-034 Random out_ready toggling during "abc" and the 56-byte case -> identical byte sequences to the unstalled runs; data_out stable throughout every stall; no byte lost or duplicated.
REQ-035 reset_n pulsed low while in ZERO -> outputs drop to 0 asynchronously; a following "abc" yields exactly the REQ-031 stream.
REQ-036 Two back-to-back 3-byte messages with msg_valid held high -> second message's first byte accepted the cycle after the first msg_end; second length field = 0x18.
